// File: rtl/display_page_scheduler_if.sv
// Channel write handshake, rotation controls and digit outputs of the display page scheduler.
interface display_page_scheduler_if;
   logic [3:0]  ch_valid;
   logic [63:0] ch_data;
   logic [3:0]  ch_ack;
   logic [3:0]  ch_enable;
   logic        next_btn;
   logic        hold;
   logic [3:0]  digit0;
   logic [3:0]  digit1;
   logic [3:0]  digit2;
   logic [3:0]  digit3;
   logic [1:0]  page;
   logic        page_valid;

   modport master (
      output ch_valid, ch_data, ch_enable, next_btn, hold,
      input  ch_ack, digit0, digit1, digit2, digit3, page, page_valid
   );

   modport slave (
      input  ch_valid, ch_data, ch_enable, next_btn, hold,
      output ch_ack, digit0, digit1, digit2, digit3, page, page_valid
   );
endinterface

// File: rtl/display_page_scheduler.sv
// Rotates the 4-digit display between up to four sensor channels held in shadow registers,
// with dwell/blank timing, manual advance, hold, stale-data dashes and leading-zero blanking.
module display_page_scheduler #(
   parameter int         DWELL_CYCLES = 100000000,
   parameter int         BLANK_CYCLES = 250000,
   parameter int         STALE_LIMIT  = 8,
   parameter logic [3:0] BLANK_CODE   = 4'hF,
   parameter logic [3:0] DASH_CODE    = 4'hE,
   parameter bit         LZB          = 1'b1
) (
   input logic                      i_sys_clk,
   input logic                      i_reset,
   display_page_scheduler_if.slave  if_bus
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int SW = $clog2(STALE_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t          r_state;
   logic [1:0]      r_page;
   logic [DW-1:0]   r_dwell;
   logic            r_dwell_parked;
   logic [BW-1:0]   r_blank;
   logic [15:0]     r_shadow [4];
   logic [3:0]      r_never_written;
   logic [SW-1:0]   r_stale [4];
   logic [3:0]      r_ack;
   logic [15:0]     r_digits;
   logic            r_page_valid;

   state_t          w_state_nxt;
   logic [1:0]      w_page_nxt;
   logic [DW-1:0]   w_dwell_nxt;
   logic            w_parked_nxt;
   logic [BW-1:0]   w_blank_nxt;
   logic            w_term;
   logic            w_advance;
   logic            w_stale_event;
   logic            w_page_stale;
   logic [1:0]      w_next_idx;
   logic [1:0]      w_lowest_idx;
   logic [15:0]     w_digits_nxt;

   // Next enabled channel strictly after cur with wrap; returns cur when it is the only one.
   function automatic logic [1:0] next_enabled(input logic [3:0] en, input logic [1:0] cur);
      logic [1:0] res;
      logic [1:0] idx;
      res = cur;
      for (int k = 3; k >= 1; k--) begin
         idx = cur + 2'(k);
         res = en[idx] ? idx : res;
      end
      return res;
   endfunction

   function automatic logic [1:0] lowest_enabled(input logic [3:0] en);
      logic [1:0] res;
      res = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         res = en[k] ? 2'(k) : res;
      end
      return res;
   endfunction

   // Blank digit3..digit1 while they and every higher digit are zero; digit0 always shown.
   function automatic logic [15:0] apply_lzb(input logic [15:0] d);
      logic z3;
      logic z2;
      logic z1;
      z3 = LZB && (d[15:12] == 4'd0);
      z2 = z3 && (d[11:8] == 4'd0);
      z1 = z2 && (d[7:4] == 4'd0);
      return {z3 ? BLANK_CODE : d[15:12],
              z2 ? BLANK_CODE : d[11:8],
              z1 ? BLANK_CODE : d[7:4],
              d[3:0]};
   endfunction

   assign w_term        = (r_dwell == DW'(DWELL_CYCLES - 1));
   assign w_advance     = (w_term && !if_bus.hold) || if_bus.next_btn || !if_bus.ch_enable[r_page];
   assign w_stale_event = (r_state == ST_SHOW) && w_term && !r_dwell_parked;
   assign w_next_idx    = next_enabled(if_bus.ch_enable, r_page);
   assign w_lowest_idx  = lowest_enabled(if_bus.ch_enable);

   // Page FSM next-state, dwell timer and blank timer.
   always_comb begin
      w_state_nxt  = r_state;
      w_page_nxt   = r_page;
      w_dwell_nxt  = r_dwell;
      w_parked_nxt = r_dwell_parked;
      w_blank_nxt  = r_blank;
      if (if_bus.ch_enable == 4'd0) begin
         w_state_nxt  = ST_IDLE;
         w_dwell_nxt  = DW'(0);
         w_parked_nxt = 1'b0;
         w_blank_nxt  = BW'(0);
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt  = ST_BLANK;
               w_page_nxt   = w_lowest_idx;
               w_dwell_nxt  = DW'(0);
               w_parked_nxt = 1'b0;
               w_blank_nxt  = BW'(0);
            end
            ST_BLANK: begin
               w_dwell_nxt  = DW'(0);
               w_parked_nxt = 1'b0;
               if (r_blank == BW'(BLANK_CYCLES - 1)) begin
                  w_state_nxt = ST_SHOW;
                  w_blank_nxt = BW'(0);
               end else begin
                  w_blank_nxt = r_blank + BW'(1);
               end
            end
            ST_SHOW: begin
               if (w_advance) begin
                  w_dwell_nxt  = DW'(0);
                  w_parked_nxt = 1'b0;
                  if (w_next_idx != r_page) begin
                     w_page_nxt  = w_next_idx;
                     w_state_nxt = ST_BLANK;
                  end else begin
                     w_state_nxt = ST_SHOW;
                  end
               end else if (w_term) begin
                  // Held at terminal: park so the stale event fires only once.
                  w_parked_nxt = 1'b1;
               end else begin
                  w_dwell_nxt = r_dwell + DW'(1);
               end
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_dwell_nxt  = DW'(0);
               w_parked_nxt = 1'b0;
               w_blank_nxt  = BW'(0);
            end
         endcase
      end
   end

   // Digit image for the page that will be current after this edge.
   always_comb begin
      w_page_stale = r_never_written[w_page_nxt] || (r_stale[w_page_nxt] == SW'(STALE_LIMIT));
      if (w_state_nxt == ST_SHOW) begin
         if (w_page_stale) begin
            w_digits_nxt = {4{DASH_CODE}};
         end else begin
            w_digits_nxt = apply_lzb(r_shadow[w_page_nxt]);
         end
      end else begin
         w_digits_nxt = {4{BLANK_CODE}};
      end
   end

   // FSM, timers and registered outputs.
   always_ff @(posedge i_sys_clk) begin
      if (!i_reset) begin
         r_state        <= ST_IDLE;
         r_page         <= 2'd0;
         r_dwell        <= DW'(0);
         r_dwell_parked <= 1'b0;
         r_blank        <= BW'(0);
         r_digits       <= {4{BLANK_CODE}};
         r_page_valid   <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_page         <= w_page_nxt;
         r_dwell        <= w_dwell_nxt;
         r_dwell_parked <= w_parked_nxt;
         r_blank        <= w_blank_nxt;
         r_digits       <= w_digits_nxt;
         r_page_valid   <= (w_state_nxt != ST_IDLE);
      end
   end

   // Per-channel capture handshake and stale tracking.
   always_ff @(posedge i_sys_clk) begin
      if (!i_reset) begin
         r_ack           <= 4'd0;
         r_never_written <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            r_shadow[i] <= 16'd0;
            r_stale[i]  <= SW'(0);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (if_bus.ch_valid[i] && !r_ack[i]) begin
               r_ack[i]           <= 1'b1;
               r_shadow[i]        <= if_bus.ch_data[16*i +: 16];
               r_never_written[i] <= 1'b0;
               r_stale[i]         <= SW'(0);
            end else begin
               r_ack[i] <= 1'b0;
               if (w_stale_event && (r_stale[i] != SW'(STALE_LIMIT))) begin
                  r_stale[i] <= r_stale[i] + SW'(1);
               end
            end
         end
      end
   end

   assign if_bus.ch_ack     = r_ack;
   assign if_bus.digit0     = r_digits[3:0];
   assign if_bus.digit1     = r_digits[7:4];
   assign if_bus.digit2     = r_digits[11:8];
   assign if_bus.digit3     = r_digits[15:12];
   assign if_bus.page       = r_page;
   assign if_bus.page_valid = r_page_valid;

endmodule

// File: doc/display_page_scheduler.md
Name: display_page_scheduler

Overview:
Time-shares the 4-digit seven-segment display between up to four sensor channels (e.g. temperature, humidity, pressure, wind). Each channel pushes a 16-bit BCD reading through a valid/ack handshake into a shadow register. The scheduler rotates through enabled channels on a dwell timer, with optional manual advance, hold, inter-page blanking, stale-data dashes and leading-zero blanking. Its digit0..digit3 outputs drive the existing display block directly.

Parameters:
DWELL_CYCLES, 100000000, sys_clk cycles each page is shown (SHOW state).
BLANK_CYCLES, 250000, sys_clk cycles of blank output between pages (minimum 1).
STALE_LIMIT, 8, dwell-terminal events without a write before a channel shows dashes (minimum 1).
BLANK_CODE, 4'hF, digit code that renders as all segments off.
DASH_CODE, 4'hE, digit code that renders as a centre dash.
LZB, 1, 1 = blank leading zeros on digit3..digit1.

Ports:
sys_clk  in  1  system clock
reset  in  1  synchronous, active-low reset, sampled on rising sys_clk
ch_valid  in  4  per-channel write request
ch_data  in  64  channel i BCD at [16i+15:16i]; nibble [16i+15:16i+12] maps to digit3
ch_ack  out  4  one-cycle capture acknowledge, per channel
ch_enable  in  4  1 = page included in rotation
next_btn  in  1  debounced single-cycle pulse: advance page now
hold  in  1  1 = freeze automatic rotation
digit0  out  4  least-significant digit code
digit1  out  4  digit code
digit2  out  4  digit code
digit3  out  4  most-significant digit code
page  out  2  index of channel currently selected
page_valid  out  1  1 = at least one channel enabled and state is not IDLE

Behaviour:
- Reset (reset=0 at edge): state=IDLE; page=0; digit0..3=BLANK_CODE; ch_ack=0; page_valid=0; shadows=0; all never_written flags=1; stale counters=0; dwell timer=0; blank timer=0. Takes priority over all other events, in any state.
- Handshake: ch_valid[i]=1 at edge t with ch_ack[i]=0 -> shadow[i]<=data, never_written[i]<=0, stale[i]<=0; ch_ack[i]=1 during cycle t+1 only. ch_valid[i] is ignored while ch_ack[i]=1, so a channel captures at most once per 2 cycles. Producer holds data until ack. Capture is independent of state and of ch_enable.
- Stale: a global dwell terminal event occurs whenever the dwell timer reaches DWELL_CYCLES-1 in SHOW, whether or not hold=1. Each event increments every stale[i], saturating at STALE_LIMIT. A channel is stale if never_written=1 or stale=STALE_LIMIT.
- FSM states: IDLE, BLANK, SHOW.
- IDLE: outputs are BLANK_CODE. When ch_enable!=0, page<=lowest enabled index, then go to BLANK.
- BLANK: outputs are BLANK_CODE and page_valid=1. Runs BLANK_CYCLES cycles, then goes to SHOW. Dwell timer is held at 0.
- SHOW: dwell timer increments each cycle. Advance when any of these hold: (timer=DWELL_CYCLES-1 and hold=0), next_btn=1, or ch_enable[page]=0.
- Advance: page<=next enabled index searched upward from page+1 with wrap, resolved in one cycle. Dwell timer clears and state goes to BLANK. If the current page is the only enabled one, page is unchanged, the timer clears and state stays SHOW with no blanking. Simultaneous causes produce a single one-step advance. With hold=1 the timer saturates at DWELL_CYCLES-1.
- Any state: ch_enable=0 -> IDLE on the next edge, page_valid=0, page holds its last value.
- Digit outputs are registered. In SHOW, a stale page shows DASH_CODE on all four digits. Otherwise the output is shadow[page] with LZB applied: digit3, then digit2, then digit1 become BLANK_CODE while they and all higher digits are 0. digit0 is never blanked.
- Latency: an advance event at edge t updates page at t+1, and digits go BLANK_CODE at t+1. A shadow write to the current page at edge t appears on the digits at t+2.

Test Plan:
All scenarios use DWELL_CYCLES=10, BLANK_CYCLES=2, STALE_LIMIT=3.
1. Reset, ch_enable=4'b0101, then ch_valid[0] with data 16'h1234 -> ch_ack[0]=1 for one cycle; after 2 BLANK cycles page=0, digit3..0=1,2,3,4, page_valid=1.
2. Channels 0 and 2 written and enabled, hold=0 -> after 10 SHOW cycles page=2 with 2 blank cycles, next dwell page=0; channels 1 and 3 never selected.
3. hold=1 for 30 cycles -> page is unchanged; next_btn pulse -> page advances once; next_btn coincident with timer terminal -> exactly one step.
4. No write to ch2 across 3 dwell events -> digits all DASH_CODE; write 16'h0045 -> ack, and with LZB=1 digits show BLANK,BLANK,4,5; 16'h0000 -> BLANK,BLANK,BLANK,0.
5. Clear ch_enable[page] mid-SHOW -> advance via BLANK next edge; ch_enable=0 -> IDLE, BLANK_CODE outputs, page_valid=0.
6. Assert reset mid-BLANK, and again while ch_ack=1 -> all outputs at reset values on the next edge; ch_valid held through reset is captured once after release.
